// File: rtl/gpu_net_endpoint.sv
// NoC endpoint for one GPU. Link flits are routed to the local RX queue, the
// one-entry forward slot, or both. GPU flits share the registered link output with forwarded traffic.

module gpu_net_endpoint_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         ACLK,
   input  logic         ARESETn,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW:0]             wr_ptr, rd_ptr;

   // The extra pointer MSB tells full apart from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         mem    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

module gpu_net_endpoint #(
   parameter logic [5:0] NODE_ID    = 6'd16,
   parameter int         FIFO_DEPTH = 4,
   parameter int         CNT_W      = 16
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic [15:0]      gpu_tx_data,
   input  logic             gpu_tx_valid,
   output logic             gpu_tx_ready,
   output logic [15:0]      gpu_rx_data,
   output logic             gpu_rx_valid,
   input  logic             gpu_rx_ready,
   input  logic [15:0]      link_in_data,
   input  logic             link_in_valid,
   output logic             link_in_ready,
   output logic [15:0]      link_out_data,
   output logic             link_out_valid,
   input  logic             link_out_ready,
   output logic [CNT_W-1:0] tx_cnt,
   output logic [CNT_W-1:0] rx_cnt,
   output logic [CNT_W-1:0] fwd_cnt
);
   localparam logic [5:0] BCAST = 6'h3F;

   typedef struct packed {
      logic [5:0] dest;
      logic [9:0] payload;
   } flit_t;

   typedef enum logic {SRC_TX, SRC_FWD} src_e;

   flit_t       in_flit;
   logic        is_local, is_bcast;
   logic        lin_fire, rx_push, fwd_load, out_fire, can_load;
   logic        txq_full, txq_empty, rxq_full, rxq_empty;
   logic [15:0] txq_head;
   logic        fwd_valid;
   logic [15:0] fwd_data;
   logic        grant_tx, grant_fwd;
   src_e        out_src, prio;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign in_flit  = link_in_data;
   assign is_local = (in_flit.dest == NODE_ID);
   assign is_bcast = (in_flit.dest == BCAST);

   assign gpu_tx_ready  = !txq_full;
   assign gpu_rx_valid  = !rxq_empty;
   assign link_in_ready = !rxq_full && !fwd_valid;

   assign lin_fire = link_in_valid && link_in_ready;
   assign rx_push  = lin_fire && (is_local || is_bcast);
   assign fwd_load = lin_fire && !is_local;
   assign out_fire = link_out_valid && link_out_ready;
   assign can_load = !link_out_valid || link_out_ready;

   gpu_net_endpoint_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_txq (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .push(gpu_tx_valid && gpu_tx_ready), .pop(grant_tx), .din(gpu_tx_data),
      .head(txq_head), .full(txq_full), .empty(txq_empty)
   );

   gpu_net_endpoint_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_rxq (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .push(rx_push), .pop(gpu_rx_valid && gpu_rx_ready), .din(link_in_data),
      .head(gpu_rx_data), .full(rxq_full), .empty(rxq_empty)
   );

   // prio names the source that wins the next contended grant.
   always_comb begin
      grant_tx  = 1'b0;
      grant_fwd = 1'b0;
      if (can_load) begin
         if (fwd_valid && !txq_empty) begin
            if (prio == SRC_FWD) grant_fwd = 1'b1;
            else                 grant_tx  = 1'b1;
         end else if (fwd_valid) begin
            grant_fwd = 1'b1;
         end else if (!txq_empty) begin
            grant_tx = 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         fwd_valid      <= 1'b0;
         fwd_data       <= '0;
         link_out_valid <= 1'b0;
         link_out_data  <= '0;
         out_src        <= SRC_TX;
         prio           <= SRC_TX;
         tx_cnt         <= '0;
         rx_cnt         <= '0;
         fwd_cnt        <= '0;
      end else begin
         if (fwd_load) begin
            fwd_valid <= 1'b1;
            fwd_data  <= link_in_data;
         end else if (grant_fwd) begin
            fwd_valid <= 1'b0;
         end

         if (grant_fwd || grant_tx) begin
            link_out_valid <= 1'b1;
            link_out_data  <= grant_fwd ? fwd_data : txq_head;
            out_src        <= grant_fwd ? SRC_FWD : SRC_TX;
            prio           <= grant_fwd ? SRC_TX : SRC_FWD;
         end else if (out_fire) begin
            link_out_valid <= 1'b0;
         end

         if (out_fire && out_src == SRC_TX)  tx_cnt  <= sat_inc(tx_cnt);
         if (out_fire && out_src == SRC_FWD) fwd_cnt <= sat_inc(fwd_cnt);
         if (rx_push)                        rx_cnt  <= sat_inc(rx_cnt);
      end
   end
endmodule

// File: tb/tb_gpu_net_endpoint.sv
// Bench for gpu_net_endpoint: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with a mid-run reset.

module tb_gpu_net_endpoint;
   localparam int         D     = 4;
   localparam int         CW    = 4;
   localparam int         CMAX  = (1 << CW) - 1;
   localparam logic [5:0] ID    = 6'd16;

   logic          ACLK = 1'b0;
   logic          ARESETn = 1'b1;
   logic [15:0]   gpu_tx_data = '0;
   logic          gpu_tx_valid = 1'b0;
   logic          gpu_tx_ready;
   logic [15:0]   gpu_rx_data;
   logic          gpu_rx_valid;
   logic          gpu_rx_ready = 1'b1;
   logic [15:0]   link_in_data = '0;
   logic          link_in_valid = 1'b0;
   logic          link_in_ready;
   logic [15:0]   link_out_data;
   logic          link_out_valid;
   logic          link_out_ready = 1'b1;
   logic [CW-1:0] tx_cnt, rx_cnt, fwd_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   gpu_net_endpoint #(.NODE_ID(ID), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .gpu_tx_data(gpu_tx_data), .gpu_tx_valid(gpu_tx_valid), .gpu_tx_ready(gpu_tx_ready),
      .gpu_rx_data(gpu_rx_data), .gpu_rx_valid(gpu_rx_valid), .gpu_rx_ready(gpu_rx_ready),
      .link_in_data(link_in_data), .link_in_valid(link_in_valid), .link_in_ready(link_in_ready),
      .link_out_data(link_out_data), .link_out_valid(link_out_valid), .link_out_ready(link_out_ready),
      .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .fwd_cnt(fwd_cnt)
   );

   always #5 ACLK = ~ACLK;

   // Reference model: transaction-level queues and a pending-slot flag.
   logic [15:0] m_rxq[$];
   logic [15:0] m_txq[$];
   bit          m_fwd_v = 0;
   logic [15:0] m_fwd_d = '0;
   bit          m_out_v = 0;
   logic [15:0] m_out_d = '0;
   bit          m_out_fwd = 0;
   bit          m_prio_fwd = 0;
   int          m_tx_cnt = 0, m_rx_cnt = 0, m_fwd_cnt = 0;

   task automatic m_reset();
      m_rxq.delete();
      m_txq.delete();
      m_fwd_v = 0; m_fwd_d = '0;
      m_out_v = 0; m_out_d = '0; m_out_fwd = 0; m_prio_fwd = 0;
      m_tx_cnt = 0; m_rx_cnt = 0; m_fwd_cnt = 0;
   endtask

   task automatic m_step();
      bit tx_ok, lin_ok, rx_ok, lo, ld, pick_fwd;
      logic [5:0] dst;
      tx_ok  = gpu_tx_valid && (m_txq.size() < D);
      lin_ok = link_in_valid && (m_rxq.size() < D) && !m_fwd_v;
      rx_ok  = gpu_rx_ready && (m_rxq.size() > 0);
      lo     = m_out_v && link_out_ready;
      if (lo) begin
         if (m_out_fwd) begin if (m_fwd_cnt < CMAX) m_fwd_cnt++; end
         else           begin if (m_tx_cnt  < CMAX) m_tx_cnt++;  end
      end
      ld = (!m_out_v || link_out_ready) && (m_fwd_v || m_txq.size() > 0);
      if (ld) begin
         pick_fwd = m_fwd_v && (m_txq.size() == 0 || m_prio_fwd);
         if (pick_fwd) begin
            m_out_d = m_fwd_d;
            m_fwd_v = 0;
         end else begin
            m_out_d = m_txq.pop_front();
         end
         m_out_v    = 1;
         m_out_fwd  = pick_fwd;
         m_prio_fwd = !pick_fwd;
      end else if (lo) begin
         m_out_v = 0;
      end
      if (rx_ok) void'(m_rxq.pop_front());
      if (tx_ok) m_txq.push_back(gpu_tx_data);
      if (lin_ok) begin
         dst = link_in_data[15:10];
         if (dst == ID || dst == 6'h3F) begin
            m_rxq.push_back(link_in_data);
            if (m_rx_cnt < CMAX) m_rx_cnt++;
         end
         if (dst != ID) begin
            m_fwd_v = 1;
            m_fwd_d = link_in_data;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge ACLK or negedge ARESETn);
         if (!ARESETn) m_reset();
         else          m_step();
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge ACLK);
         chk("gpu_tx_ready",   16'(gpu_tx_ready),   16'(m_txq.size() < D));
         chk("gpu_rx_valid",   16'(gpu_rx_valid),   16'(m_rxq.size() > 0));
         if (m_rxq.size() > 0) chk("gpu_rx_data", gpu_rx_data, m_rxq[0]);
         chk("link_in_ready",  16'(link_in_ready),  16'((m_rxq.size() < D) && !m_fwd_v));
         chk("link_out_valid", 16'(link_out_valid), 16'(m_out_v));
         chk("link_out_data",  link_out_data,       m_out_d);
         chk("tx_cnt",  16'(tx_cnt),  16'(m_tx_cnt));
         chk("rx_cnt",  16'(rx_cnt),  16'(m_rx_cnt));
         chk("fwd_cnt", 16'(fwd_cnt), 16'(m_fwd_cnt));
      end
   end

   // Inputs change 2 time units after the falling edge, away from both clock edges.
   task automatic tick();
      @(negedge ACLK);
      #2;
   endtask

   task automatic idle_inputs();
      gpu_tx_valid = 0; link_in_valid = 0;
      gpu_rx_ready = 1; link_out_ready = 1;
   endtask

   task automatic do_reset();
      idle_inputs();
      ARESETn = 0;
      tick(); tick();
      ARESETn = 1;
      tick();
   endtask

   task automatic send_link(input logic [15:0] d);
      bit r;
      r = 0;
      link_in_data = d; link_in_valid = 1;
      for (int i = 0; i < 50 && !r; i++) begin
         r = link_in_ready;
         tick();
      end
      link_in_valid = 0;
      chk("send_link_accepted", 16'(r), 16'd1);
   endtask

   task automatic send_gpu(input logic [15:0] d);
      bit r;
      r = 0;
      gpu_tx_data = d; gpu_tx_valid = 1;
      for (int i = 0; i < 50 && !r; i++) begin
         r = gpu_tx_ready;
         tick();
      end
      gpu_tx_valid = 0;
      chk("send_gpu_accepted", 16'(r), 16'd1);
   endtask

   function automatic logic [15:0] rand_flit();
      logic [5:0] d;
      case ($urandom_range(0, 3))
         0:       d = ID;
         1:       d = 6'h3F;
         default: d = 6'($urandom);
      endcase
      return {d, 10'($urandom)};
   endfunction

   task automatic rand_run(input int n, input int lo_pct);
      bit f_tx, f_lin;
      for (int i = 0; i < n; i++) begin
         f_tx  = gpu_tx_valid && gpu_tx_ready;
         f_lin = link_in_valid && link_in_ready;
         tick();
         if (!gpu_tx_valid || f_tx) begin
            gpu_tx_valid = 1'($urandom_range(0, 1));
            gpu_tx_data  = rand_flit();
         end
         if (!link_in_valid || f_lin) begin
            link_in_valid = 1'($urandom_range(0, 1));
            link_in_data  = rand_flit();
         end
         gpu_rx_ready   = ($urandom_range(0, 3) != 0);
         link_out_ready = ($urandom_range(0, 99) < lo_pct);
      end
   endtask

   initial begin
      logic [15:0] got[$];
      bit          lf;
      tick();
      do_reset();

      // Local delivery.
      send_link(16'h4123);
      chk("t2_rx_valid", 16'(gpu_rx_valid), 16'd1);
      chk("t2_rx_data",  gpu_rx_data,       16'h4123);
      chk("t2_rx_cnt",   16'(rx_cnt),       16'd1);
      chk("t2_out_valid", 16'(link_out_valid), 16'd0);
      tick();
      chk("t2_out_valid_later", 16'(link_out_valid), 16'd0);

      // Pass-through, two-cycle latency.
      do_reset();
      send_link(16'h4523);
      chk("t3_out_valid_t1", 16'(link_out_valid), 16'd0);
      tick();
      chk("t3_out_valid_t2", 16'(link_out_valid), 16'd1);
      chk("t3_out_data",     link_out_data,       16'h4523);
      tick();
      chk("t3_fwd_cnt", 16'(fwd_cnt), 16'd1);
      chk("t3_rx_cnt",  16'(rx_cnt),  16'd0);

      // Broadcast goes both ways.
      do_reset();
      send_link(16'hFC01);
      chk("t4_rx_data", gpu_rx_data, 16'hFC01);
      chk("t4_rx_cnt",  16'(rx_cnt), 16'd1);
      tick();
      chk("t4_out_data", link_out_data, 16'hFC01);
      chk("t4_out_valid", 16'(link_out_valid), 16'd1);
      tick();
      chk("t4_fwd_cnt", 16'(fwd_cnt), 16'd1);

      // Contention under backpressure, then round-robin drain.
      do_reset();
      link_out_ready = 0;
      send_gpu(16'h4401);
      send_gpu(16'h4402);
      send_link(16'h4803);
      tick(); tick();
      chk("t5_held_data", link_out_data, 16'h4401);
      chk("t5_lin_ready_blocked", 16'(link_in_ready), 16'd0);
      link_out_ready = 1;
      got.delete();
      for (int i = 0; i < 20 && got.size() < 3; i++) begin
         if (link_out_valid && link_out_ready) got.push_back(link_out_data);
         tick();
      end
      chk("t5_count", 16'(got.size()), 16'd3);
      if (got.size() == 3) begin
         chk("t5_order0", got[0], 16'h4401);
         chk("t5_order1", got[1], 16'h4803);
         chk("t5_order2", got[2], 16'h4402);
      end
      chk("t5_tx_cnt",  16'(tx_cnt),  16'd2);
      chk("t5_fwd_cnt", 16'(fwd_cnt), 16'd1);

      // RX queue fill and in-order drain.
      do_reset();
      gpu_rx_ready = 0;
      for (int k = 1; k <= 4; k++) send_link(16'(16'h4000 + k));
      chk("t6_lin_ready_full", 16'(link_in_ready), 16'd0);
      link_in_data = 16'h4005; link_in_valid = 1;
      tick(); tick(); tick();
      chk("t6_rx_cnt_held", 16'(rx_cnt), 16'd4);
      gpu_rx_ready = 1;
      got.delete();
      for (int i = 0; i < 30 && got.size() < 5; i++) begin
         lf = link_in_valid && link_in_ready;
         if (gpu_rx_valid && gpu_rx_ready) got.push_back(gpu_rx_data);
         tick();
         if (lf) link_in_valid = 0;
      end
      chk("t6_count", 16'(got.size()), 16'd5);
      for (int k = 0; k < 5 && k < got.size(); k++)
         chk("t6_order", got[k], 16'(16'h4001 + k));
      chk("t6_rx_cnt", 16'(rx_cnt), 16'd5);

      // Randomized traffic with varying output backpressure; counters saturate.
      do_reset();
      rand_run(800, 80);
      rand_run(400, 15);

      // Reset while traffic is in flight.
      ARESETn = 0;
      #1;
      chk("t1_rx_valid",  16'(gpu_rx_valid),  16'd0);
      chk("t1_out_valid", 16'(link_out_valid), 16'd0);
      chk("t1_out_data",  link_out_data,       16'd0);
      chk("t1_tx_ready",  16'(gpu_tx_ready),   16'd1);
      chk("t1_lin_ready", 16'(link_in_ready),  16'd1);
      chk("t1_cnts", 16'({tx_cnt, rx_cnt, fwd_cnt}), 16'd0);
      idle_inputs();
      tick();
      ARESETn = 1;
      tick();
      rand_run(800, 60);
      idle_inputs();
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
